// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver that packs each group of 2*NUM_CHANNEL bytes into one pixel frame.
// Define FRAME_TIMEOUT_EN to build the idle timeout that drops stale partial frames.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on rxs
// START    | confirming the start bit at its midpoint
// DATA     | sampling 8 data bits, LSB first, one per bit period
// STOP     | sampling the stop bit, committing or rejecting the byte
// WAITHIGH | after a framing error, waiting for the line to return high
module uart_frame_rx #(
  parameter int unsigned NUM_CHANNEL  = 4,
  parameter int unsigned PIXEL_WIDTH  = 16,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     serialIn,
  output logic [7:0]                               byteData,
  output logic                                     byteValid,
  output logic [NUM_CHANNEL-1:0][PIXEL_WIDTH-1:0]  pixelData,
  output logic                                     pixelValid,
  output logic [$clog2(2*NUM_CHANNEL)-1:0]         byteCount,
  output logic                                     frameErr,
  output logic                                     frameTimeout
);

  localparam int unsigned NumBytes = 2 * NUM_CHANNEL;
  localparam int unsigned BcW      = $clog2(NumBytes);
  localparam int unsigned CcW      = $clog2(CLKS_PER_BIT);
  localparam bit ParamsOk = (CLKS_PER_BIT >= 4) && (CLKS_PER_BIT % 2 == 0) &&
                            (PIXEL_WIDTH == 16) && (TIMEOUT_BITS > 0) && (NUM_CHANNEL > 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_STOP     = 3'd3,
    S_WAITHIGH = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic                         rx_meta_q, rxs_q;
  logic [CcW-1:0]               clk_cnt_q, clk_cnt_d;
  logic [2:0]                   bit_cnt_q, bit_cnt_d;
  logic [7:0]                   shift_q, shift_d;
  logic [BcW-1:0]               byte_cnt_q, byte_cnt_d;
  logic [NumBytes-2:0][7:0]     shadow_q, shadow_d;
  logic [7:0]                   byte_data_q, byte_data_d;
  logic                         byte_valid_q, byte_valid_d;
  logic [NumBytes-1:0][7:0]     pixel_data_q, pixel_data_d;
  logic                         pixel_valid_q, pixel_valid_d;
  logic                         frame_err_q, frame_err_d;
  logic [NumBytes-1:0][7:0]     frame_bytes;
  logic                         byte_good;
  logic                         timeout_hit;

  // Completed frame: earlier bytes from the shadow slots, the last byte straight from the shifter.
  assign frame_bytes = {shift_q, shadow_q};

  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q + CcW'(1);
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_cnt_d    = byte_cnt_q;
    shadow_d      = shadow_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    byte_good     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == CcW'(CLKS_PER_BIT/2 - 1)) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == CcW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == CcW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          if (rxs_q) begin
            state_d   = S_IDLE;
            byte_good = 1'b1;
          end else begin
            state_d     = S_WAITHIGH;
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
          end
        end
      end
      S_WAITHIGH: begin
        clk_cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) byte_cnt_d = '0;

    if (byte_good) begin
      byte_data_d  = shift_q;
      byte_valid_d = 1'b1;
      if (byte_cnt_q == BcW'(NumBytes - 1)) begin
        pixel_data_d  = frame_bytes;
        pixel_valid_d = 1'b1;
        byte_cnt_d    = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + BcW'(1);
        for (int i = 0; i < NumBytes - 1; i++) begin
          if (byte_cnt_q == BcW'(i)) shadow_d[i] = shift_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      shadow_q      <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_meta_q     <= serialIn;
      rxs_q         <= rx_meta_q;
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      shadow_q      <= shadow_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) assert (ParamsOk);
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IdleW         = $clog2(TimeoutCycles);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             frame_timeout_q;

  // Only a partial frame sitting in IDLE ages; any line activity restarts the count.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == S_IDLE && byte_cnt_q != '0) begin
      if (idle_cnt_q == IdleW'(TimeoutCycles - 1)) timeout_hit = 1'b1;
      else idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q      <= '0;
      frame_timeout_q <= 1'b0;
    end else begin
      idle_cnt_q      <= idle_cnt_d;
      frame_timeout_q <= timeout_hit;
    end
  end

  assign frameTimeout = frame_timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign frameTimeout = 1'b0;
`endif

  assign byteData   = byte_data_q;
  assign byteValid  = byte_valid_q;
  assign pixelData  = pixel_data_q;
  assign pixelValid = pixel_valid_q;
  assign byteCount  = byte_cnt_q;
  assign frameErr   = frame_err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes hand-computed expectations,
// a negedge monitor pops them whenever the DUT strobes an output.
module tb_uart_frame_rx;
  localparam int C = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              serialIn = 1'b1;
  logic [7:0]        byteData;
  logic              byteValid;
  logic [3:0][15:0]  pixelData;
  logic              pixelValid;
  logic [2:0]        byteCount;
  logic              frameErr;
  logic              frameTimeout;

  uart_frame_rx #(.NUM_CHANNEL(4), .PIXEL_WIDTH(16), .CLKS_PER_BIT(C), .TIMEOUT_BITS(20)) dut (
    .clk(clk), .reset(reset), .serialIn(serialIn),
    .byteData(byteData), .byteValid(byteValid),
    .pixelData(pixelData), .pixelValid(pixelValid),
    .byteCount(byteCount), .frameErr(frameErr), .frameTimeout(frameTimeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [7:0]       exp_byte[$];
  logic [3:0][15:0] exp_pix[$];
  int               exp_err = 0;
  int               exp_to = 0;
  longint           pix_times[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (byteValid) begin
          if (exp_byte.size() == 0) chk("unexpected_byteValid", 64'(byteData), 64'hX);
          else chk("byteData", 64'(byteData), 64'(exp_byte.pop_front()));
        end
        if (pixelValid) begin
          pix_times.push_back(cycle);
          chk("pixel_with_byteValid", 64'(byteValid), 64'd1);
          if (exp_pix.size() == 0) chk("unexpected_pixelValid", 64'(pixelData), 64'hX);
          else chk("pixelData", 64'(pixelData), 64'(exp_pix.pop_front()));
        end
        if (frameErr) begin
          chk("frameErr_expected", 64'(exp_err > 0), 64'd1);
          chk("frameErr_excl_byteValid", 64'(byteValid), 64'd0);
          if (exp_err > 0) exp_err--;
        end
        if (frameTimeout) begin
          chk("frameTimeout_expected", 64'(exp_to > 0), 64'd1);
          chk("frameTimeout_excl_byteValid", 64'(byteValid), 64'd0);
          if (exp_to > 0) exp_to--;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) exp_byte.push_back(b);
    else exp_err++;
    serialIn = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      repeat (C) @(negedge clk);
    end
    serialIn = stop_ok;
    repeat (C) @(negedge clk);
    serialIn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] first);
    for (int i = 0; i < 8; i++) send_byte(first + 8'(i), 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    serialIn = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byteData"},     64'(byteData), 64'd0);
    chk({tag, "_byteValid"},    64'(byteValid), 64'd0);
    chk({tag, "_pixelData"},    64'(pixelData), 64'd0);
    chk({tag, "_pixelValid"},   64'(pixelValid), 64'd0);
    chk({tag, "_byteCount"},    64'(byteCount), 64'd0);
    chk({tag, "_frameErr"},     64'(frameErr), 64'd0);
    chk({tag, "_frameTimeout"}, 64'(frameTimeout), 64'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    idle(4);

    // Single frame 0x01..0x08
    exp_pix.push_back({16'h0807, 16'h0605, 16'h0403, 16'h0201});
    send_frame(8'h01);
    idle(2 * C);
    chk("single_byteCount", 64'(byteCount), 64'd0);

    // Stop-bit error on byte 3 drops the partial frame
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h24, 1'b0);
    idle(2 * C);
    chk("stoperr_byteCount", 64'(byteCount), 64'd0);
    chk("stoperr_pending", 64'(exp_err), 64'd0);
    exp_pix.push_back({16'h1817, 16'h1615, 16'h1413, 16'h1211});
    send_frame(8'h11);
    idle(2 * C);
    chk("after_err_byteCount", 64'(byteCount), 64'd0);

    // Start glitch shorter than half a bit
    serialIn = 1'b0;
    idle(C / 4);
    serialIn = 1'b1;
    idle(2 * C);
    chk("glitch_byteCount", 64'(byteCount), 64'd0);
    send_byte(8'hA5, 1'b1);
    idle(C);
    chk("glitch_then_byte_count", 64'(byteCount), 64'd1);
    chk("glitch_then_byteData", 64'(byteData), 64'hA5);

    // Partial frame left idle for 20 bit periods
    do_reset();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1);
`ifdef FRAME_TIMEOUT_EN
    exp_to++;
`endif
    send_byte(8'hA3, 1'b1);
    idle(21 * C);
`ifdef FRAME_TIMEOUT_EN
    chk("timeout_byteCount", 64'(byteCount), 64'd0);
    chk("timeout_pending", 64'(exp_to), 64'd0);
    exp_pix.push_back({16'h0807, 16'h0605, 16'h0403, 16'h0201});
    send_frame(8'h01);
    idle(C);
    chk("timeout_frame_byteCount", 64'(byteCount), 64'd0);
`else
    chk("notimeout_byteCount", 64'(byteCount), 64'd3);
    exp_pix.push_back({16'h0504, 16'h0302, 16'h01A3, 16'hA2A1});
    send_frame(8'h01);
    idle(C);
    chk("notimeout_frame_byteCount", 64'(byteCount), 64'd3);
`endif

    // Reset in the middle of data bit 4 clears everything
    send_byte(8'h31, 1'b1);
    serialIn = 1'b0;
    idle(C);
    for (int i = 0; i < 4; i++) begin
      serialIn = i[0];
      idle(C);
    end
    serialIn = 1'b1;
    idle(C / 2);
    reset = 1'b1;
    idle(2);
    chk_all_zero("midreset");
    reset = 1'b0;
    idle(4 * C);
    chk("post_reset_byteCount", 64'(byteCount), 64'd0);

    // Two frames back to back with no idle between bytes
    pix_times.delete();
    exp_pix.push_back({16'h4847, 16'h4645, 16'h4443, 16'h4241});
    exp_pix.push_back({16'h5857, 16'h5655, 16'h5453, 16'h5251});
    send_frame(8'h41);
    send_frame(8'h51);
    idle(2 * C);
    chk("b2b_pixel_count", 64'(pix_times.size()), 64'd2);
    if (pix_times.size() == 2)
      chk("b2b_spacing", 64'(pix_times[1] - pix_times[0]), 64'(80 * C));
    chk("b2b_byteCount", 64'(byteCount), 64'd0);

    idle(2 * C);
    chk("byte_queue_drained", 64'(exp_byte.size()), 64'd0);
    chk("pixel_queue_drained", 64'(exp_pix.size()), 64'd0);
    chk("err_drained", 64'(exp_err), 64'd0);
    chk("timeout_drained", 64'(exp_to), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial receiver for the pixel link, the stage directly downstream of the 4-channel UART pixel transmitter. It deserializes 8N1 UART bytes from `serialIn` and reassembles each group of `2*NUM_CHANNEL` bytes into one pixel vector. Byte order is channel 0 low, channel 0 high, channel 1 low, and so on. Each completed frame is presented with a one-cycle `pixelValid` strobe. It is used on the host side and in the loopback bench to check transmitter output.

## Interface
- `NUM_CHANNEL`, default 4: pixels per frame; the frame is `2*NUM_CHANNEL` bytes.
- `PIXEL_WIDTH`, default 16: fixed at 16, two bytes per pixel.
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit; must be ≥4 and even.
- `TIMEOUT_BITS`, default 20: idle bit periods before a partial frame is dropped. Used only under `FRAME_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset`, in, 1: synchronous, active-high.
- `serialIn`, in, 1: asynchronous UART line, idle high.
- `byteData`, out, 8: last good byte received.
- `byteValid`, out, 1: one-cycle strobe, `byteData` is new.
- `pixelData`, out, `[NUM_CHANNEL-1:0][15:0]`: last completed frame.
- `pixelValid`, out, 1: one-cycle strobe, `pixelData` is new.
- `byteCount`, out, `$clog2(2*NUM_CHANNEL)`: number of bytes of the current frame already received.
- `frameErr`, out, 1: one-cycle strobe on a stop-bit error.
- `frameTimeout`, out, 1: one-cycle strobe when a partial frame is dropped. Tied to 0 without the macro.

## Operation
- **Input synchronizer:** `serialIn` passes through a 2-FF synchronizer (reset value 1). All sampling uses the synchronized line `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, WAITHIGH. A bit counter `bitCnt` (0..7) and a clock counter `clkCnt` (0..`CLKS_PER_BIT`-1) drive the timing.
- **IDLE:** on `rxs`==0, go to START with `clkCnt`=0.
- **START:** at `clkCnt`==`CLKS_PER_BIT/2-1`, sample `rxs`.
  - If 0, go to DATA with `clkCnt`=0 and `bitCnt`=0.
  - If 1, it was a glitch: return to IDLE with no outputs.
- **DATA:** at `clkCnt`==`CLKS_PER_BIT-1`, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
- **STOP:** at `clkCnt`==`CLKS_PER_BIT-1`, sample `rxs`.
  - If 1, the byte is good: go to IDLE.
  - If 0, it is a framing error: pulse `frameErr`, discard the byte, set `byteCount` to 0 (partial frame dropped), and go to WAITHIGH.
- **WAITHIGH:** return to IDLE once `rxs`==1.
- **Good byte handling:**
  - `byteData` ← byte; `byteValid` pulses.
  - The byte goes into shadow slot `byteCount`. An even index is the low byte of channel `byteCount/2`; an odd index is the high byte.
  - If `byteCount`==`2*NUM_CHANNEL-1`: `pixelData` ← shadow slots plus the current byte, `pixelValid` pulses, and `byteCount` wraps to 0.
  - Otherwise `byteCount` increments.
- **Output holding:** `pixelData` changes only at frame completion. `byteData` changes only on a good byte.

## Timing
- **Reset values:** all outputs 0. State IDLE, counters 0, synchronizer 1. Reset has priority over every event. Reset mid-byte or mid-frame abandons the byte and partial frame; `pixelData` is cleared to 0.
- **Sample points:** the synchronized falling edge is cycle 0. The stop bit is sampled at cycle `CLKS_PER_BIT/2-1 + 9*CLKS_PER_BIT`.
- **Strobe latency:** `byteValid`, `pixelValid`, `frameErr` and `frameTimeout` are registered and assert the cycle after the deciding sample. `pixelValid` coincides with the `byteValid` of the last byte.
- **Pin-to-edge latency:** 2 cycles from the `serialIn` pin to `rxs`.
- **Back-to-back bytes:** a start bit immediately after the stop bit is accepted. The FSM re-enters IDLE half a bit before the stop bit ends, so a start edge arriving then is detected.
- **Strobe exclusivity:** at most one of `byteValid` and `frameErr` per byte. `frameTimeout` never coincides with `byteValid`.

## Configuration
- **`FRAME_TIMEOUT_EN` defined:**
  - An idle counter runs while in IDLE with `byteCount`≠0. It clears on leaving IDLE or on reset.
  - On reaching `TIMEOUT_BITS*CLKS_PER_BIT` cycles: `byteCount` ← 0, `frameTimeout` pulses, the counter clears.
- **Not defined:** no counter is built; `frameTimeout`=0. A partial frame waits indefinitely and is completed by the next bytes.

## Test plan
- **Single frame:** send bytes 0x01..0x08 → eight `byteValid` pulses and one `pixelValid`, with `pixelData[0..3]` = 0x0201, 0x0403, 0x0605, 0x0807, and `byteCount` back to 0.
- **Stop-bit error:** frame with the byte 3 stop bit forced 0 → one `frameErr`, only 3 `byteValid`, no `pixelValid`, `byteCount`=0. A following frame of 0x11..0x18 gives `pixelData[0]`=0x1211 and `[3]`=0x1817.
- **Start glitch:** line low for `CLKS_PER_BIT/4` cycles → no strobes; FSM in IDLE; a following byte 0xA5 is received correctly.
- **Timeout, macro on:** 3 bytes, then idle for 20 bit periods → `frameTimeout` once, `byteCount`=0. Bytes 0x01..0x08 then give the single-frame result.
- **Timeout, macro off:** same stimulus → no `frameTimeout`, and `pixelValid` fires after 5 of the new bytes.
- **Reset and back-to-back:** reset asserted at data bit 4 → all outputs 0. Next, two frames sent back-to-back with no idle → two `pixelValid` pulses exactly `80*CLKS_PER_BIT` cycles apart.
